// File: rtl/relu_node_streamer.sv
// Captures one vector of NODES ReLU outputs and streams (index, value) pairs over valid/ready.
// Optional zero-skipping for sparse vectors is enabled by defining RELU_SKIP_ZERO_EN.
module relu_node_streamer #(
    parameter int NODES       = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NODES*DATA_WIDTH-1:0] node_values,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INDEX_WIDTH-1:0]      out_index,
    output logic [DATA_WIDTH-1:0]       out_value,
    output logic                        out_last,
    output logic                        done,
    output logic                        queue_empty
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NODES - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   buffer_q [NODES];
    logic [INDEX_WIDTH-1:0]  ptr_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   cur_value_s;
    logic                    present_s;
    logic                    cur_last_s;

`ifdef RELU_SKIP_ZERO_EN
    logic [NODES-1:0]        mask_q;
    logic                    later_nz_s;

    // Mask lookup: is the current node nonzero, and does any nonzero node remain above it
    always_comb begin
        present_s  = 1'b0;
        later_nz_s = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            if (ptr_q == INDEX_WIDTH'(i)) begin
                present_s = mask_q[i];
            end else if ((INDEX_WIDTH'(i) > ptr_q) && mask_q[i]) begin
                later_nz_s = 1'b1;
            end else begin
                later_nz_s = later_nz_s;
            end
        end
        cur_last_s = ~later_nz_s;
    end
`else
    // Without zero-skipping every node is emitted and the final index is the last one
    always_comb begin
        present_s  = 1'b1;
        cur_last_s = (ptr_q == LAST_IDX);
    end
`endif

    // Read mux selecting the buffered value at the stream pointer
    always_comb begin
        cur_value_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NODES; i++) begin
            if (ptr_q == INDEX_WIDTH'(i)) begin
                cur_value_s = buffer_q[i];
            end else begin
                cur_value_s = cur_value_s;
            end
        end
    end

    // Output decode straight from registered state; index and value are zeroed when not valid
    always_comb begin
        load_ready  = (state_q == IDLE);
        queue_empty = (state_q == IDLE);
        out_valid   = (state_q == STREAM) && present_s;
        done        = done_q;
        if (out_valid) begin
            out_index = ptr_q;
            out_value = cur_value_s;
            out_last  = cur_last_s;
        end else begin
            out_index = {INDEX_WIDTH{1'b0}};
            out_value = {DATA_WIDTH{1'b0}};
            out_last  = 1'b0;
        end
    end

    // Load/stream state machine; reset aborts any vector in flight without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= {INDEX_WIDTH{1'b0}};
            done_q  <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                buffer_q[i] <= {DATA_WIDTH{1'b0}};
            end
`ifdef RELU_SKIP_ZERO_EN
            mask_q  <= {NODES{1'b0}};
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < NODES; i++) begin
                            buffer_q[i] <= node_values[DATA_WIDTH*i +: DATA_WIDTH];
`ifdef RELU_SKIP_ZERO_EN
                            mask_q[i]   <= |node_values[DATA_WIDTH*i +: DATA_WIDTH];
`endif
                        end
                        ptr_q   <= {INDEX_WIDTH{1'b0}};
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (!present_s) begin
                        // Zero entry: scan past it without a handshake
                        if (ptr_q == LAST_IDX) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + ONE_IDX;
                        end
                    end else if (out_ready) begin
                        if (cur_last_s) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + ONE_IDX;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= {INDEX_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_node_streamer.sv
// Directed self-checking bench for relu_node_streamer with NODES=4, DATA_WIDTH=8.
module tb_relu_node_streamer;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] node_values;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_index;
    logic [7:0]  out_value;
    logic        out_last;
    logic        done;
    logic        queue_empty;

    int checks;
    int errors;

    relu_node_streamer #(
        .NODES(4),
        .DATA_WIDTH(8),
        .INDEX_WIDTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .node_values(node_values),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_value(out_value),
        .out_last(out_last),
        .done(done),
        .queue_empty(queue_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] vec);
        load_valid  = 1'b1;
        node_values = vec;
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, out_index, out_value, out_last, done, queue_empty, load_ready} !== 15'b0_00_00000000_0_0_1_1) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%0d d=%0d l=%b done=%b qe=%b lr=%b want 0 0 0 0 0 1 1",
                     out_valid, out_index, out_value, out_last, done, queue_empty, load_ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({out_valid, done, queue_empty, load_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_after: got v=%b done=%b qe=%b lr=%b want 0 0 1 1", out_valid, done, queue_empty, load_ready);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        do_load({8'd4, 8'd3, 8'd2, 8'd1});
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_index, out_value, out_last, done, queue_empty} !== {1'b1, 2'(k), 8'(k + 1), (k == 3), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stream_k%0d: got v=%b i=%0d d=%0d l=%b done=%b qe=%b want 1 %0d %0d %0b 0 0",
                         k, out_valid, out_index, out_value, out_last, done, queue_empty, k, k + 1, (k == 3));
            end
            tick();
        end
        checks++;
        if ({out_valid, done, queue_empty, load_ready} !== 4'b0111) begin
            errors++;
            $display("FAIL stream_done: got v=%b done=%b qe=%b lr=%b want 0 1 1 1", out_valid, done, queue_empty, load_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_once: got done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        xfers = 0;
        out_ready = 1'b0;
        do_load({8'd4, 8'd3, 8'd2, 8'd1});
        for (int c = 0; c < 20; c++) begin
            if (xfers == 4) break;
            out_ready = (c % 3 == 0);
            checks++;
            if ({out_valid, out_index, out_value} !== {1'b1, 2'(xfers), 8'(xfers + 1)}) begin
                errors++;
                $display("FAIL bp_c%0d: got v=%b i=%0d d=%0d want 1 %0d %0d", c, out_valid, out_index, out_value, xfers, xfers + 1);
            end
            if (out_ready) xfers++;
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if ({out_valid, done, queue_empty} !== 3'b011) begin
            errors++;
            $display("FAIL bp_done: got v=%b done=%b qe=%b want 0 1 1", out_valid, done, queue_empty);
        end
        tick();
    endtask

    task automatic test_ignore_load();
        out_ready = 1'b1;
        do_load({8'd4, 8'd3, 8'd2, 8'd1});
        for (int k = 0; k < 4; k++) begin
            load_valid  = (k < 3);
            node_values = 32'hAABBCCDD;
            checks++;
            if ({load_ready, out_valid, out_index, out_value} !== {1'b0, 1'b1, 2'(k), 8'(k + 1)}) begin
                errors++;
                $display("FAIL ignore_k%0d: got lr=%b v=%b i=%0d d=%0d want 0 1 %0d %0d",
                         k, load_ready, out_valid, out_index, out_value, k, k + 1);
            end
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if ({done, queue_empty} !== 2'b11) begin
            errors++;
            $display("FAIL ignore_done: got done=%b qe=%b want 1 1", done, queue_empty);
        end
        tick();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        do_load({8'd4, 8'd3, 8'd2, 8'd1});
        tick();
        tick();
        checks++;
        if ({out_valid, out_index, out_value} !== {1'b1, 2'd2, 8'd3}) begin
            errors++;
            $display("FAIL abort_pre: got v=%b i=%0d d=%0d want 1 2 3", out_valid, out_index, out_value);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({out_valid, queue_empty, done, load_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL abort_state: got v=%b qe=%b done=%b lr=%b want 0 1 0 1", out_valid, queue_empty, done, load_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done=%b want 0", done);
        end
        do_load({8'd8, 8'd7, 8'd6, 8'd5});
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_index, out_value} !== {1'b1, 2'(k), 8'(k + 5)}) begin
                errors++;
                $display("FAIL abort_reload_k%0d: got v=%b i=%0d d=%0d want 1 %0d %0d", k, out_valid, out_index, out_value, k, k + 5);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload_done: got done=%b want 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_load({8'd4, 8'd3, 8'd2, 8'd1});
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if ({done, load_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done: got done=%b lr=%b want 1 1", done, load_ready);
        end
        do_load({8'd40, 8'd30, 8'd20, 8'd10});
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_index, out_value, out_last} !== {1'b1, 2'(k), 8'(10 * (k + 1)), (k == 3)}) begin
                errors++;
                $display("FAIL b2b_k%0d: got v=%b i=%0d d=%0d l=%b want 1 %0d %0d %0b",
                         k, out_valid, out_index, out_value, out_last, k, 10 * (k + 1), (k == 3));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2: got done=%b want 1", done);
        end
        tick();
    endtask

    task automatic test_zero_nodes();
        out_ready = 1'b1;
        do_load({8'd0, 8'd0, 8'd9, 8'd0});
`ifdef RELU_SKIP_ZERO_EN
        checks++;
        if ({out_valid, done} !== 2'b00) begin
            errors++;
            $display("FAIL skip_first: got v=%b done=%b want 0 0", out_valid, done);
        end
        tick();
        checks++;
        if ({out_valid, out_index, out_value, out_last} !== {1'b1, 2'd1, 8'd9, 1'b1}) begin
            errors++;
            $display("FAIL skip_xfer: got v=%b i=%0d d=%0d l=%b want 1 1 9 1", out_valid, out_index, out_value, out_last);
        end
        tick();
        checks++;
        if ({out_valid, done} !== 2'b01) begin
            errors++;
            $display("FAIL skip_done: got v=%b done=%b want 0 1", out_valid, done);
        end
        tick();
        do_load(32'h0000_0000);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({out_valid, done} !== 2'b00) begin
                errors++;
                $display("FAIL skip_allzero_c%0d: got v=%b done=%b want 0 0", c, out_valid, done);
            end
            tick();
        end
        checks++;
        if ({out_valid, done, queue_empty} !== 3'b011) begin
            errors++;
            $display("FAIL skip_allzero_done: got v=%b done=%b qe=%b want 0 1 1", out_valid, done, queue_empty);
        end
        tick();
`else
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_index, out_value, out_last} !== {1'b1, 2'(k), ((k == 1) ? 8'd9 : 8'd0), (k == 3)}) begin
                errors++;
                $display("FAIL zero_emit_k%0d: got v=%b i=%0d d=%0d l=%b want 1 %0d %0d %0b",
                         k, out_valid, out_index, out_value, out_last, k, (k == 1) ? 9 : 0, (k == 3));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got done=%b want 1", done);
        end
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        load_valid  = 1'b0;
        out_ready   = 1'b0;
        node_values = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_ignore_load();
        test_abort();
        test_back_to_back();
        test_zero_nodes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
